// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Shares the CPU main and address buses between the microcode control unit
// and up to NREQ external bus masters. Ownership only changes hands at
// instruction boundaries (step counter restart). A one-cycle dead cycle
// separates the control word and any external grant in both directions.
//
// Parameters:
//   NREQ        number of external requesters (1..8)
//   HOLD_MAX    maximum consecutive grant cycles per tenure, 0 = unlimited
//
// Ports:
//   clk          in   system clock, rising edge
//   rstn         in   asynchronous active-low reset
//   step_resetn  in   low in the cycle the microcode step counter restarts
//   req          in   per-requester level request, held until done
//   gnt          out  one-hot registered grant
//   ctrlen       out  registered, 1 = control word drives the buses
//   busy         out  1 whenever the arbiter is not in RUN
//   ovf          out  sticky flag, a tenure was cut by HOLD_MAX
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int NREQ     = 2,
    parameter int HOLD_MAX = 255
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            step_resetn,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            ctrlen,
    output logic            busy,
    output logic            ovf
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_HANDOVER = 2'd1;
    localparam logic [1:0] ST_GRANT    = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    localparam logic [CW-1:0] CNT_LAST   = (HOLD_MAX > 0) ? CW'(HOLD_MAX - 1) : '0;
    localparam logic [IW-1:0] LAST_RESET = IW'(NREQ - 1);

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   win_q, win_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            granted_q, granted_d;
    logic            ovf_q, ovf_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            ctrlen_q, ctrlen_d;

    logic [IW-1:0]   pick;
    logic            found;
    int              idx;

    // Round-robin search: first set request starting just above the most
    // recently granted index, wrapping around. Reset leaves last at NREQ-1
    // so requester 0 wins the first contest.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_q) + i) % NREQ;
            if (!found && req[idx[IW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IW-1:0];
            end
        end
    end

    // Tenure sequencing. The winner is latched at the boundary and only its
    // own request line matters afterwards; other requesters are ignored
    // until the next contest. The boundary strobe is only honoured in RUN,
    // so a request held across RELEASE waits a whole instruction.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        granted_d = granted_q;
        ovf_d     = ovf_q;

        case (state_q)
            ST_RUN: begin
                if (!step_resetn && found) begin
                    state_d = ST_HANDOVER;
                    win_d   = pick;
                end
            end
            ST_HANDOVER: begin
                // A request withdrawn during turnaround gets no grant and
                // does not advance the round-robin pointer.
                granted_d = req[win_q];
                cnt_d     = '0;
                state_d   = req[win_q] ? ST_GRANT : ST_RELEASE;
            end
            ST_GRANT: begin
                cnt_d = cnt_q + 1'b1;
                if (!req[win_q]) begin
                    state_d = ST_RELEASE;
                end else if ((HOLD_MAX != 0) && (cnt_q == CNT_LAST)) begin
                    state_d = ST_RELEASE;
                    ovf_d   = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (granted_q) begin
                    last_d = win_q;
                end
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Outputs are decoded from the next state so they come straight off
    // flops, which keeps gnt and ctrlen glitch-free on the shared buses.
    always_comb begin
        gnt_d    = '0;
        ctrlen_d = (state_d == ST_RUN);
        if (state_d == ST_GRANT) begin
            gnt_d = NREQ'(1) << win_d;
        end
    end

    // Asynchronous reset abandons any tenure immediately: gnt drops and the
    // control word reclaims the buses without waiting for a clock.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_RUN;
            win_q     <= '0;
            last_q    <= LAST_RESET;
            cnt_q     <= '0;
            granted_q <= 1'b0;
            ovf_q     <= 1'b0;
            gnt_q     <= '0;
            ctrlen_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            granted_q <= granted_d;
            ovf_q     <= ovf_d;
            gnt_q     <= gnt_d;
            ctrlen_q  <= ctrlen_d;
        end
    end

    assign gnt    = gnt_q;
    assign ctrlen = ctrlen_q;
    assign busy   = (state_q != ST_RUN);
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed bench for bus_arbiter. Two instances share clock, reset and the
// boundary strobe: dutA uses default parameters (NREQ=2, HOLD_MAX=255),
// dutB uses HOLD_MAX=4 to exercise the tenure cut. Inputs change 1 time unit
// after each rising edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    logic       clk;
    logic       rstn;
    logic       stepResetn;
    logic [1:0] reqA, reqB;
    logic [1:0] gntA, gntB;
    logic       ctrlenA, ctrlenB;
    logic       busyA, busyB;
    logic       ovfA, ovfB;

    int testsRun;
    int testsFailed;

    bus_arbiter #(.NREQ(2), .HOLD_MAX(255)) dutA (
        .clk        (clk),
        .rstn       (rstn),
        .step_resetn(stepResetn),
        .req        (reqA),
        .gnt        (gntA),
        .ctrlen     (ctrlenA),
        .busy       (busyA),
        .ovf        (ovfA)
    );

    bus_arbiter #(.NREQ(2), .HOLD_MAX(4)) dutB (
        .clk        (clk),
        .rstn       (rstn),
        .step_resetn(stepResetn),
        .req        (reqB),
        .gnt        (gntB),
        .ctrlen     (ctrlenB),
        .busy       (busyB),
        .ovf        (ovfB)
    );

    // Free-running 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then advance to just after the next edge.
    task automatic applyStimulus(input logic sr, input logic [1:0] ra, input logic [1:0] rb);
        stepResetn = sr;
        reqA       = ra;
        reqB       = rb;
        @(posedge clk);
        #1;
    endtask

    // Compare {gnt, ctrlen, busy, ovf} of the selected instance.
    task automatic checkOutput(input string tag, input logic useB, input logic [1:0] expGnt,
                               input logic expCtrlen, input logic expBusy, input logic expOvf);
        logic [4:0] observed;
        logic [4:0] expected;
        observed = useB ? {gntB, ctrlenB, busyB, ovfB} : {gntA, ctrlenA, busyA, ovfA};
        expected = {expGnt, expCtrlen, expBusy, expOvf};
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed {gnt,ctrlen,busy,ovf}=%b expected %b", tag, observed, expected);
        end
    endtask

    // Directed sequence; expected values are hand-derived from the arbiter's
    // RUN -> HANDOVER -> GRANT -> RELEASE -> RUN behaviour.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rstn        = 1'b0;
        stepResetn  = 1'b1;
        reqA        = 2'b00;
        reqB        = 2'b00;

        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        checkOutput("reset_A", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("reset_B", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);

        // Idle with a boundary every 4 clocks.
        for (int k = 0; k < 12; k++) begin
            applyStimulus((k % 4 == 3) ? 1'b0 : 1'b1, 2'b00, 2'b00);
            checkOutput("idle", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        end

        // Request rising one cycle after a strobe waits for the next one.
        applyStimulus(1'b0, 2'b00, 2'b00);
        applyStimulus(1'b1, 2'b01, 2'b00);
        checkOutput("late_req_waits", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 2'b00);
        checkOutput("mid_instr_req", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b01, 2'b00);
        checkOutput("handover_dead", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b01, 2'b00);
        checkOutput("grant0_first", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 2'b01, 2'b00);
            checkOutput("grant0_hold", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 2'b00, 2'b00);
        checkOutput("release_dead", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b00, 2'b00);
        checkOutput("back_to_run", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);

        // Fresh reset so the round-robin starts from index 0 again.
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Round-robin with both requesting: 01, 10, 01.
        applyStimulus(1'b0, 2'b11, 2'b00);
        checkOutput("rr_handover1", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b11, 2'b00);
        checkOutput("rr_first", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b11, 2'b00);
        checkOutput("rr_first_hold", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b10, 2'b00);
        checkOutput("rr_release1", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'b10, 2'b00);
        checkOutput("strobe_in_release_ignored", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b10, 2'b00);
        checkOutput("needs_fresh_boundary", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b11, 2'b00);
        checkOutput("rr_handover2", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b11, 2'b00);
        checkOutput("rr_second", 1'b0, 2'b10, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b01, 2'b00);
        checkOutput("rr_release2", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b01, 2'b00);
        checkOutput("rr_run2", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);

        // req[0] withdrawn during HANDOVER: no grant, pointer stays at 1.
        applyStimulus(1'b0, 2'b01, 2'b00);
        checkOutput("wd_handover", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b00, 2'b00);
        checkOutput("wd_no_grant", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b00, 2'b00);
        checkOutput("wd_ctrlen_back", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);

        // Third contest goes to 0 only if the pointer was left at 1.
        applyStimulus(1'b1, 2'b11, 2'b00);
        applyStimulus(1'b0, 2'b11, 2'b00);
        checkOutput("rr_handover3", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b11, 2'b00);
        checkOutput("rr_third_last_kept", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b00, 2'b00);
        applyStimulus(1'b1, 2'b00, 2'b00);
        checkOutput("rr_done", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);

        // HOLD_MAX=4 on dutB with req[0] held indefinitely.
        applyStimulus(1'b0, 2'b00, 2'b01);
        checkOutput("hold_handover", 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 2'b00, 2'b01);
            checkOutput("hold_grant", 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 2'b00, 2'b01);
        checkOutput("hold_cut_ovf", 1'b1, 2'b00, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 2'b00, 2'b01);
        checkOutput("hold_run_ovf", 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b00, 2'b01);
        checkOutput("hold_wait_boundary", 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'b00, 2'b01);
        checkOutput("hold_handover2", 1'b1, 2'b00, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 2'b00, 2'b01);
        checkOutput("hold_regrant", 1'b1, 2'b01, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a grant on dutA (pointer at 0,
        // so req=10 picks index 1); dutB is mid-grant with ovf set.
        applyStimulus(1'b0, 2'b10, 2'b01);
        checkOutput("pre_reset_handover", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b10, 2'b01);
        checkOutput("pre_reset_grant", 1'b0, 2'b10, 1'b0, 1'b1, 1'b0);
        #3;
        rstn = 1'b0;
        #1;
        checkOutput("async_reset_A", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("async_reset_B", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        applyStimulus(1'b0, 2'b11, 2'b00);
        checkOutput("post_reset_handover", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b11, 2'b00);
        checkOutput("post_reset_first_is_0", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b00, 2'b00);
        applyStimulus(1'b1, 2'b00, 2'b00);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
